// File: rtl/adc_capture_ctrl.sv
// ADC capture engine: decimates ADC samples into a FIFO and streams them as one AXI4-Stream packet.
// Optional ramp test source is enabled with ADC_CAPTURE_TEST_PATTERN_EN.
module adc_capture_ctrl #(
  parameter int ADC_W      = 12,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             cfg_start,
  input  logic             cfg_abort,
  input  logic [15:0]      cfg_num_samples,
  input  logic [7:0]       cfg_decim,
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
  input  logic             cfg_pattern,
`endif
  input  logic [ADC_W-1:0] adc_data,
  input  logic             adc_valid,
  output logic [31:0]      m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic             sts_busy,
  output logic             sts_done,
  output logic             sts_overflow,
  output logic [15:0]      sts_count
);

  // state   | meaning
  // IDLE    | waiting for cfg_start
  // CAPTURE | decimating adc_valid samples into the FIFO
  // DRAIN   | all samples captured, emptying the FIFO
  // DONE    | packet complete, sts_done high, start re-arms

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [15:0]       num_q;
  logic [7:0]        decim_q;
  logic [7:0]        decim_cnt_q;
  logic [15:0]       index_q;
  logic              done_q;
  logic              ovf_q;
  logic [32:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       fill_q;
  logic              tvalid_q;

  logic              start_ok;
  logic              keep;
  logic              full;
  logic              wr_en;
  logic              rd_en;
  logic              drop;
  logic              last_write;
  logic [ADC_W-1:0]  sample;
  logic [31:0]       wr_word;

`ifdef ADC_CAPTURE_TEST_PATTERN_EN
  logic              pattern_q;
  logic [ADC_W-1:0]  ramp_q;

  assign sample = pattern_q ? ramp_q : adc_data;
`else
  assign sample = adc_data;
`endif

  assign start_ok   = cfg_start && !cfg_abort && (state_q == S_IDLE || state_q == S_DONE);
  assign keep       = (state_q == S_CAPTURE) && adc_valid && (decim_cnt_q == decim_q) && !cfg_abort;
  assign full       = (fill_q == (AW+1)'(FIFO_DEPTH));
  assign rd_en      = tvalid_q && m_axis_tready;
  // A read in the same cycle frees an entry, so a full FIFO can still accept the write.
  assign wr_en      = keep && (!full || rd_en);
  assign drop       = keep && !wr_en;
  assign last_write = wr_en && (index_q == num_q - 16'd1);

  always_comb begin
    wr_word              = '0;
    wr_word[31:16]       = index_q;
    wr_word[ADC_W-1:0]   = sample;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) state_d = (cfg_num_samples == 16'd0) ? S_DONE : S_CAPTURE;
      end
      S_CAPTURE: begin
        if (last_write) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (rd_en && m_axis_tlast) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    if (cfg_abort) state_d = S_IDLE;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge ACLK) begin
    if (wr_en) mem[wr_ptr_q] <= {(index_q == num_q - 16'd1), wr_word};
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      num_q       <= '0;
      decim_q     <= '0;
      decim_cnt_q <= '0;
      index_q     <= '0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      tvalid_q    <= 1'b0;
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
      pattern_q   <= 1'b0;
      ramp_q      <= '0;
`endif
    end else if (cfg_abort) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      tvalid_q <= 1'b0;
    end else begin
      if (start_ok) begin
        num_q       <= cfg_num_samples;
        decim_q     <= cfg_decim;
        // Preloading the counter with the ratio makes the first valid sample a keeper.
        decim_cnt_q <= cfg_decim;
        index_q     <= '0;
        ovf_q       <= 1'b0;
        done_q      <= (cfg_num_samples == 16'd0);
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
        pattern_q   <= cfg_pattern;
        ramp_q      <= '0;
`endif
      end else if (state_d == S_DONE) begin
        done_q <= 1'b1;
      end

      if (state_q == S_CAPTURE && adc_valid) begin
        decim_cnt_q <= (decim_cnt_q == decim_q) ? 8'd0 : decim_cnt_q + 8'd1;
      end

`ifdef ADC_CAPTURE_TEST_PATTERN_EN
      if (keep) ramp_q <= ramp_q + 1'b1;
`endif

      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        index_q  <= index_q + 16'd1;
      end
      if (drop) ovf_q <= 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;

      fill_q   <= fill_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
      // Only entries already present before this edge become visible, adding one cycle of latency.
      tvalid_q <= ((fill_q - (AW+1)'(rd_en)) != '0);
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tvalid_q ? mem[rd_ptr_q][31:0] : 32'd0;
  assign m_axis_tlast  = tvalid_q ? mem[rd_ptr_q][32] : 1'b0;
  assign sts_busy      = (state_q == S_CAPTURE) || (state_q == S_DRAIN);
  assign sts_done      = done_q;
  assign sts_overflow  = ovf_q;
  assign sts_count     = index_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Self-checking bench for adc_capture_ctrl: expected beats are queued as samples are driven
// and compared by a stream monitor as the DUT emits them.
module tb_adc_capture_ctrl;
  localparam int ADC_W      = 12;
  localparam int FIFO_DEPTH = 16;

  logic              ACLK = 1'b0;
  logic              ARESET;
  logic              cfg_start;
  logic              cfg_abort;
  logic [15:0]       cfg_num_samples;
  logic [7:0]        cfg_decim;
  logic              cfg_pattern;
  logic [ADC_W-1:0]  adc_data;
  logic              adc_valid;
  logic [31:0]       m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic              sts_busy;
  logic              sts_done;
  logic              sts_overflow;
  logic [15:0]       sts_count;

  int                checks = 0;
  int                errors = 0;
  int                beat_cnt = 0;
  logic [32:0]       exp_q[$];
  logic [32:0]       mon_exp;

  adc_capture_ctrl #(.ADC_W(ADC_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .ACLK            (ACLK),
    .ARESET          (ARESET),
    .cfg_start       (cfg_start),
    .cfg_abort       (cfg_abort),
    .cfg_num_samples (cfg_num_samples),
    .cfg_decim       (cfg_decim),
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
    .cfg_pattern     (cfg_pattern),
`endif
    .adc_data        (adc_data),
    .adc_valid       (adc_valid),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .m_axis_tlast    (m_axis_tlast),
    .sts_busy        (sts_busy),
    .sts_done        (sts_done),
    .sts_overflow    (sts_overflow),
    .sts_count       (sts_count)
  );

  always #5 ACLK = ~ACLK;

  function automatic logic [32:0] exp_word(int idx, int data, bit last);
    logic [31:0] w;
    w = {16'(idx), 16'h0000};
    w[ADC_W-1:0] = ADC_W'(data);
    return {last, w};
  endfunction

  always @(negedge ACLK) begin
    if (!ARESET && m_axis_tvalid && m_axis_tready) begin
      beat_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got tlast=%b tdata=%h, required no beat", m_axis_tlast, m_axis_tdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({m_axis_tlast, m_axis_tdata} !== mon_exp) begin
          errors++;
          $display("FAIL beat_data: got tlast=%b tdata=%h, required tlast=%b tdata=%h",
                   m_axis_tlast, m_axis_tdata, mon_exp[32], mon_exp[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic pulse_start(input logic [15:0] num, input logic [7:0] decim);
    cfg_num_samples = num;
    cfg_decim       = decim;
    cfg_start       = 1'b1;
    tick();
    cfg_start       = 1'b0;
  endtask

  task automatic test_reset();
    ARESET = 1'b1; cfg_start = 0; cfg_abort = 0; cfg_num_samples = 0; cfg_decim = 0;
    cfg_pattern = 0; adc_data = 0; adc_valid = 0; m_axis_tready = 0;
    repeat (3) tick();
    checks++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== 34'd0) begin
      errors++; $display("FAIL reset_stream: got %h, required 0", {m_axis_tvalid, m_axis_tlast, m_axis_tdata});
    end
    checks++;
    if ({sts_busy, sts_done, sts_overflow, sts_count} !== 19'd0) begin
      errors++; $display("FAIL reset_status: got %h, required 0", {sts_busy, sts_done, sts_overflow, sts_count});
    end
    ARESET = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int b0 = beat_cnt;
    m_axis_tready = 1'b1;
    pulse_start(16'd4, 8'd0);
    for (int j = 0; j < 4; j++) begin
      adc_valid = 1'b1; adc_data = ADC_W'(12'h10 + j);
      exp_q.push_back(exp_word(j, 'h10 + j, j == 3));
      tick();
    end
    adc_valid = 1'b0;
    for (int i = 0; i < 100 && !sts_done; i++) tick();
    checks++;
    if (sts_done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b, required 1", sts_done); end
    checks++;
    if (sts_count !== 16'd4) begin errors++; $display("FAIL basic_count: got %0d, required 4", sts_count); end
    checks++;
    if (beat_cnt - b0 != 4 || exp_q.size() != 0) begin
      errors++; $display("FAIL basic_beats: got %0d beats, %0d pending, required 4 and 0", beat_cnt - b0, exp_q.size());
    end
    checks++;
    if (sts_busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b, required 0", sts_busy); end
  endtask

  task automatic test_decimation();
    int b0 = beat_cnt;
    int kept = 0;
    m_axis_tready = 1'b1;
    pulse_start(16'd3, 8'd2);
    for (int j = 0; j < 9; j++) begin
      adc_valid = 1'b1; adc_data = ADC_W'(j);
      if (j % 3 == 0 && kept < 3) begin
        exp_q.push_back(exp_word(kept, j, kept == 2));
        kept++;
      end
      tick();
    end
    adc_valid = 1'b0;
    for (int i = 0; i < 100 && !sts_done; i++) tick();
    checks++;
    if (sts_done !== 1'b1 || sts_count !== 16'd3) begin
      errors++; $display("FAIL decim_status: got done=%b count=%0d, required 1 and 3", sts_done, sts_count);
    end
    checks++;
    if (beat_cnt - b0 != 3 || exp_q.size() != 0) begin
      errors++; $display("FAIL decim_beats: got %0d beats, %0d pending, required 3 and 0", beat_cnt - b0, exp_q.size());
    end
  endtask

  task automatic test_overflow();
    int b0 = beat_cnt;
    m_axis_tready = 1'b0;
    pulse_start(16'd20, 8'd0);
    for (int j = 0; j < 34; j++) begin
      if (j == 30) begin
        checks++;
        if (sts_count !== 16'd16 || sts_overflow !== 1'b1 || m_axis_tvalid !== 1'b1 || beat_cnt != b0) begin
          errors++;
          $display("FAIL ovf_full: got count=%0d ovf=%b tvalid=%b beats=%0d, required 16 1 1 0",
                   sts_count, sts_overflow, m_axis_tvalid, beat_cnt - b0);
        end
      end
      m_axis_tready = (j >= 30);
      adc_valid = 1'b1; adc_data = ADC_W'('h100 + j);
      if (j < 16) exp_q.push_back(exp_word(j, 'h100 + j, 1'b0));
      if (j >= 30) exp_q.push_back(exp_word(j - 14, 'h100 + j, j == 33));
      tick();
    end
    adc_valid = 1'b0;
    for (int i = 0; i < 100 && !sts_done; i++) tick();
    checks++;
    if (sts_done !== 1'b1 || sts_overflow !== 1'b1 || sts_count !== 16'd20) begin
      errors++; $display("FAIL ovf_final: got done=%b ovf=%b count=%0d, required 1 1 20", sts_done, sts_overflow, sts_count);
    end
    checks++;
    if (beat_cnt - b0 != 20 || exp_q.size() != 0) begin
      errors++; $display("FAIL ovf_beats: got %0d beats, %0d pending, required 20 and 0", beat_cnt - b0, exp_q.size());
    end
  endtask

  task automatic test_abort();
    int b0 = beat_cnt;
    m_axis_tready = 1'b0;
    pulse_start(16'd10, 8'd0);
    for (int j = 0; j < 10; j++) begin
      adc_valid = 1'b1; adc_data = ADC_W'('h200 + j);
      exp_q.push_back(exp_word(j, 'h200 + j, j == 9));
      tick();
    end
    adc_valid = 1'b0;
    repeat (2) tick();
    m_axis_tready = 1'b1;
    repeat (5) tick();
    m_axis_tready = 1'b0;
    cfg_abort = 1'b1;
    checks++;
    if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL abort_pre_tvalid: got %b, required 1", m_axis_tvalid); end
    tick();
    cfg_abort = 1'b0;
    checks++;
    if (m_axis_tvalid !== 1'b0 || sts_busy !== 1'b0 || sts_done !== 1'b0) begin
      errors++; $display("FAIL abort_post: got tvalid=%b busy=%b done=%b, required 0 0 0", m_axis_tvalid, sts_busy, sts_done);
    end
    checks++;
    if (beat_cnt - b0 != 5 || exp_q.size() != 5) begin
      errors++; $display("FAIL abort_beats: got %0d beats, %0d pending, required 5 and 5", beat_cnt - b0, exp_q.size());
    end
    exp_q.delete();
    b0 = beat_cnt;
    m_axis_tready = 1'b1;
    pulse_start(16'd10, 8'd0);
    for (int j = 0; j < 10; j++) begin
      adc_valid = 1'b1; adc_data = ADC_W'('h300 + j);
      exp_q.push_back(exp_word(j, 'h300 + j, j == 9));
      tick();
    end
    adc_valid = 1'b0;
    for (int i = 0; i < 100 && !sts_done; i++) tick();
    checks++;
    if (sts_done !== 1'b1 || beat_cnt - b0 != 10 || exp_q.size() != 0) begin
      errors++; $display("FAIL abort_restart: got done=%b beats=%0d pending=%0d, required 1 10 0",
                         sts_done, beat_cnt - b0, exp_q.size());
    end
  endtask

  task automatic test_edge_cases();
    int b0 = beat_cnt;
    m_axis_tready = 1'b1;
    pulse_start(16'd0, 8'd0);
    checks++;
    if (sts_done !== 1'b1 || sts_busy !== 1'b0) begin
      errors++; $display("FAIL num0_done: got done=%b busy=%b, required 1 0", sts_done, sts_busy);
    end
    repeat (3) tick();
    checks++;
    if (m_axis_tvalid !== 1'b0 || beat_cnt != b0) begin
      errors++; $display("FAIL num0_beats: got tvalid=%b beats=%0d, required 0 0", m_axis_tvalid, beat_cnt - b0);
    end

    b0 = beat_cnt;
    pulse_start(16'd4, 8'd0);
    for (int j = 0; j < 4; j++) begin
      if (j == 3) begin
        checks++;
        if (sts_count !== 16'd3) begin errors++; $display("FAIL restart_count: got %0d, required 3", sts_count); end
      end
      if (j == 2) begin cfg_start = 1'b1; cfg_num_samples = 16'd2; end
      adc_valid = 1'b1; adc_data = ADC_W'('h400 + j);
      exp_q.push_back(exp_word(j, 'h400 + j, j == 3));
      tick();
      cfg_start = 1'b0;
    end
    adc_valid = 1'b0;
    for (int i = 0; i < 100 && !sts_done; i++) tick();
    checks++;
    if (sts_count !== 16'd4 || beat_cnt - b0 != 4 || exp_q.size() != 0) begin
      errors++; $display("FAIL restart_ignored: got count=%0d beats=%0d pending=%0d, required 4 4 0",
                         sts_count, beat_cnt - b0, exp_q.size());
    end

    m_axis_tready = 1'b0;
    pulse_start(16'd5, 8'd0);
    for (int j = 0; j < 5; j++) begin
      adc_valid = 1'b1; adc_data = ADC_W'('h500 + j);
      exp_q.push_back(exp_word(j, 'h500 + j, j == 4));
      tick();
    end
    adc_valid = 1'b0;
    repeat (2) tick();
    checks++;
    if (sts_busy !== 1'b1 || m_axis_tvalid !== 1'b1) begin
      errors++; $display("FAIL drain_pre: got busy=%b tvalid=%b, required 1 1", sts_busy, m_axis_tvalid);
    end
    ARESET = 1'b1;
    tick();
    checks++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, sts_busy, sts_done, sts_overflow, sts_count} !== 53'd0) begin
      errors++; $display("FAIL drain_reset: got tvalid=%b tlast=%b tdata=%h busy=%b done=%b ovf=%b count=%0d, required all 0",
                         m_axis_tvalid, m_axis_tlast, m_axis_tdata, sts_busy, sts_done, sts_overflow, sts_count);
    end
    ARESET = 1'b0;
    exp_q.delete();
    tick();
  endtask

`ifdef ADC_CAPTURE_TEST_PATTERN_EN
  task automatic test_pattern();
    int b0 = beat_cnt;
    m_axis_tready = 1'b1;
    cfg_pattern = 1'b1;
    pulse_start(16'd3, 8'd0);
    cfg_pattern = 1'b0;
    for (int j = 0; j < 3; j++) begin
      adc_valid = 1'b1; adc_data = ADC_W'($urandom);
      exp_q.push_back(exp_word(j, j, j == 2));
      tick();
    end
    adc_valid = 1'b0;
    for (int i = 0; i < 100 && !sts_done; i++) tick();
    checks++;
    if (beat_cnt - b0 != 3 || exp_q.size() != 0) begin
      errors++; $display("FAIL pattern_beats: got %0d beats, %0d pending, required 3 and 0", beat_cnt - b0, exp_q.size());
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_decimation();
    test_overflow();
    test_abort();
    test_edge_cases();
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
    test_pattern();
`endif
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
